// File: rtl/mult_pkg.sv
// mult_pkg: shared multiplier state encoding, width and ALU codops for the mulH/mulL reads.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t;
    localparam int MULT_WIDTH = 16;
    localparam logic [3:0] ALU_MULH = 4'd13;
    localparam logic [3:0] ALU_MULL = 4'd14;
endpackage

// File: rtl/mult_seq.sv
// mult_seq: radix-2 shift-add multiplier with sign correction, holding the last product on mulH/mulL.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] operando1,
    input  logic [WIDTH-1:0] operando2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mulH,
    output logic [WIDTH-1:0] mulL
);
    localparam int CW = $clog2(WIDTH);

    function automatic logic [2*WIDTH-1:0] cneg(input logic n, input logic [2*WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    mult_state_t      state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
    logic             neg;
    logic             n1, n2;
    logic [WIDTH-1:0] mag1, mag2, unused_hi1, unused_hi2;
    logic [WIDTH:0]   sum;

    assign n1 = signed_op & operando1[WIDTH-1];
    assign n2 = signed_op & operando2[WIDTH-1];
    // 0x8000 negates to itself, which is the correct unsigned magnitude
    assign {unused_hi1, mag1} = cneg(n1, {{WIDTH{1'b0}}, operando1});
    assign {unused_hi2, mag2} = cneg(n2, {{WIDTH{1'b0}}, operando2});
    assign sum = acc_lo[0] ? {1'b0, acc_hi} + {1'b0, mcand} : {1'b0, acc_hi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mulH   <= '0;
            mulL   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= mag1;
                    acc_lo <= mag2;
                    acc_hi <= '0;
                    neg    <= n1 ^ n2;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    // acc_lo doubles as the multiplier shift register
                    {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(WIDTH - 1)) ? FIX : RUN;
                end
                FIX: begin
                    {mulH, mulL} <= cneg(neg, {acc_hi, acc_lo});
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: random and corner multiplies checked through a product scoreboard, plus handshake timing.
module tb_mult_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [15:0] operando1 = '0, operando2 = '0;
    logic        busy, done;
    logic [15:0] mulH, mulL;

    int total = 0;
    int bad = 0;
    logic [31:0] q[$];
    logic [31:0] last = '0;

    mult_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .operando1(operando1), .operando2(operando2),
        .busy(busy), .done(done), .mulH(mulH), .mulL(mulL)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint pa = s ? longint'($signed(a)) : longint'(a);
        longint pb = s ? longint'($signed(b)) : longint'(b);
        return 32'(pa * pb);
    endfunction

    // returns just after the accepting edge E0
    task automatic go(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk);
        start = 1'b1;
        operando1 = a;
        operando2 = b;
        signed_op = s;
        q.push_back(model(a, b, s));
        @(negedge clk);
        start = 1'b0;
        operando1 = $urandom;
        operando2 = $urandom;
    endtask

    always @(negedge clk) begin
        if (!rst_n) last = '0;
        else begin
            chk("busy_done_overlap", 32'(busy & done), 32'd0);
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("product", {mulH, mulL}, q.pop_front());
                last = {mulH, mulL};
            end else chk("hold", {mulH, mulL}, last);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a, b;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mul", {mulH, mulL}, 32'd0);
        rst_n = 1'b1;
        // handshake timing on the first request
        go(16'h00FF, 16'h0101, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) @(negedge clk);
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("done_run", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        chk("busy_e17", {31'd0, busy}, 32'd0);
        chk("done_e17", {31'd0, done}, 32'd1);
        chk("mul_e17", {mulH, mulL}, 32'h0000FFFF);
        @(negedge clk);
        chk("done_e18", {31'd0, done}, 32'd0);
        go(16'hFFFF, 16'hFFFF, 1'b0); repeat (19) @(negedge clk);
        go(16'hFFFF, 16'h0002, 1'b1); repeat (19) @(negedge clk);
        go(16'hFFFF, 16'h0002, 1'b0); repeat (19) @(negedge clk);
        go(16'h8000, 16'h8000, 1'b1); repeat (19) @(negedge clk);
        go(16'h8000, 16'h0001, 1'b1); repeat (19) @(negedge clk);
        // start raised mid-run and held: must not be taken until IDLE at E19
        go(16'h1357, 16'h2468, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        operando1 = 16'hFEDC;
        operando2 = 16'h0123;
        signed_op = 1'b1;
        q.push_back(model(16'hFEDC, 16'h0123, 1'b1));
        repeat (14) @(negedge clk);
        chk("held_not_taken_e18", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("held_taken_e19", {31'd0, busy}, 32'd1);
        start = 1'b0;
        repeat (19) @(negedge clk);
        // reset in the middle of a multiply
        go(16'h1234, 16'h5678, 1'b0); repeat (19) @(negedge clk);
        go(16'hABCD, 16'h0F0F, 1'b0);
        repeat (7) @(negedge clk);
        #3 rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_mul", {mulH, mulL}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        go(16'd3, 16'd5, 1'b0); repeat (19) @(negedge clk);
        chk("post_rst_mul", {mulH, mulL}, 32'h0000000F);
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 7 == 0) a = 16'h8000;
            if (i % 5 == 0) b = 16'hFFFF;
            go(a, b, 1'($urandom));
            repeat (19) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
